// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and counter sizing for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int WIDTH_DEF = 4;

    // Counter must be able to hold the value WIDTH itself
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic             ge;

    // Shift the partial remainder left pulling in the next dividend bit, then trial-subtract
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        ge      = shifted >= {2'b0, divisor};
        rem_out = ge ? (WIDTH+1)'(shifted - {2'b0, divisor}) : (WIDTH+1)'(shifted);
        quo_out = {quo_in[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned divider, one quotient bit per clock
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_acc),
        .quo_in  (quo_acc),
        .divisor (div_q),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign busy = state != IDLE;
    assign done = state == DONE;

    // FSM, iteration accumulators and result registers; results load only on DONE entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            div_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state   <= RUN;
                            div_q   <= divisor;
                            rem_acc <= '0;
                            quo_acc <= dividend;
                            count   <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    rem_acc <= rem_nxt;
                    quo_acc <= quo_nxt;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state       <= DONE;
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and random checks of 4-bit and 8-bit dividers against / and %
module tb_seq_restoring_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, q4, r4;
    logic       busy4, done4, dz4;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, q8, r8;
    logic       busy8, done8, dz8;

    int n_tests = 0, n_fail = 0;
    int nd4 = 0, ns4 = 0, nd8 = 0, ns8 = 0;

    seq_restoring_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dz4)
    );

    seq_restoring_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    // Count every cycle each done is high, to compare against accepted starts
    always @(posedge clk) begin
        if (done4) nd4 <= nd4 + 1;
        if (done8) nd8 <= nd8 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int cyc, bsy;
        logic ez;
        logic [3:0] eq, er;
        ez = (b == 0);
        eq = ez ? 4'hF : a / b;
        er = ez ? a : a % b;
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        ns4++;
        cyc = 0;
        bsy = int'(busy4);
        while (!done4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            bsy += int'(busy4);
        end
        check("lat4", cyc, ez ? 0 : 4);
        check("busy4", bsy, cyc + 1);
        check("q4", q4, eq);
        check("r4", r4, er);
        check("dz4", dz4, ez);
        if (!ez) check("inv4", {int'(q4) * int'(b) + int'(r4) == int'(a), r4 < b}, 2'b11);
        @(posedge clk); #1;
        check("idle4", {done4, busy4}, 2'b00);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int cyc;
        logic ez;
        logic [7:0] eq, er;
        ez = (b == 0);
        eq = ez ? 8'hFF : a / b;
        er = ez ? a : a % b;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        ns8++;
        cyc = 0;
        while (!done8 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("lat8", cyc, ez ? 0 : 8);
        check("q8", q8, eq);
        check("r8", r8, er);
        check("dz8", dz8, ez);
        @(posedge clk); #1;
        check("idle8", {done8, busy8}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst4", {busy4, done4, q4, r4, dz4}, '0);
        check("rst8", {busy8, done8, q8, r8, dz8}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        op4(13, 3); op4(15, 1); op4(0, 5); op4(5, 7); op4(15, 15);
        op4(9, 0);  op4(6, 2);

        // Start pulses while RUN (edge 2) and DONE (edge 5) must be ignored
        @(negedge clk);
        start4 = 1'b1; a4 = 13; b4 = 3;
        @(posedge clk); #1;
        ns4++;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            start4 = (e == 2 || e == 5); a4 = 2; b4 = 1;
            @(posedge clk); #1;
            if (e == 4) check("ign_res", {done4, q4, r4, dz4}, {1'b1, 4'd4, 4'd1, 1'b0});
            if (e == 5) check("ign_hold", {busy4, done4, q4, r4}, {1'b0, 1'b0, 4'd4, 4'd1});
        end
        op4(6, 2);

        // Reset mid-operation aborts with no done pulse
        op4(9, 0);
        @(negedge clk);
        start4 = 1'b1; a4 = 13; b4 = 3;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort", {busy4, done4, q4, r4, dz4}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            seen += int'(done4);
        end
        check("abort_nodone", seen, 0);
        op4(10, 4);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                op4(4'(i), 4'(j));

        op8(200, 0);
        op8(255, 1);
        for (int k = 0; k < 1000; k++) op8(8'($urandom), 8'($urandom));

        repeat (2) @(posedge clk);
        #1;
        check("ndone4", nd4, ns4);
        check("ndone8", nd8, ns8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
